// File: rtl/spi_ram_if.sv
// Command/read-back channel between the SPI slave and spi_ram.
// The master side drives command words; the slave side returns read bytes.
interface spi_ram_if;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    modport master (output rx_data, rx_valid, input tx_data, tx_valid);
    modport slave  (input rx_data, rx_valid, output tx_data, tx_valid);
endinterface

// File: rtl/spi_ram.sv
// Byte RAM driven by 10-bit SPI command words, with independent auto-incrementing
// write/read pointers and a held read-back byte for MISO serialisation.
module spi_ram #(
    parameter int MEM_DEPTH = 256
) (
    input  logic     clk,
    input  logic     rst_n,
    spi_ram_if.slave bus
);
    localparam int         AW    = $clog2(MEM_DEPTH);
    localparam logic [8:0] DEPTH = 9'(MEM_DEPTH);
    localparam logic [7:0] LAST  = 8'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } op_t;

    typedef enum logic {TX_IDLE, TX_HOLD} tx_state_t;

    logic [7:0] mem [MEM_DEPTH];
    logic [7:0] wr_ptr, rd_ptr, tx_data_q, rd_byte;
    logic       rx_valid_q, accept, wr_in_range, rd_in_range;
    op_t        op;
    logic [7:0] payload;
    tx_state_t  state, state_nxt;

    assign op          = op_t'(bus.rx_data[9:8]);
    assign payload     = bus.rx_data[7:0];
    // rst_n in the term keeps an edge coinciding with reset from writing memory
    assign accept      = bus.rx_valid & ~rx_valid_q & rst_n;
    assign wr_in_range = {1'b0, wr_ptr} < DEPTH;
    assign rd_in_range = {1'b0, rd_ptr} < DEPTH;
    assign rd_byte     = rd_in_range ? mem[rd_ptr[AW-1:0]] : 8'h00;

    // Last legal location wraps to 0; out-of-range pointers count on to 8-bit overflow.
    function automatic logic [7:0] ptr_inc(input logic [7:0] p);
        return (p == LAST) ? 8'h00 : p + 8'h01;
    endfunction

    always_ff @(posedge clk) begin
        if (accept && op == OP_WR_DATA && wr_in_range)
            mem[wr_ptr[AW-1:0]] <= payload;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            wr_ptr     <= 8'h00;
            rd_ptr     <= 8'h00;
            tx_data_q  <= 8'h00;
        end else begin
            rx_valid_q <= bus.rx_valid;
            if (accept) begin
                case (op)
                    OP_WR_ADDR: wr_ptr <= payload;
                    OP_WR_DATA: wr_ptr <= ptr_inc(wr_ptr);
                    OP_RD_ADDR: rd_ptr <= payload;
                    OP_RD_DATA: begin
                        tx_data_q <= rd_byte;
                        rd_ptr    <= ptr_inc(rd_ptr);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= TX_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept)
            state_nxt = (op == OP_RD_DATA) ? TX_HOLD : TX_IDLE;
    end

    assign bus.tx_valid = (state == TX_HOLD);
    assign bus.tx_data  = tx_data_q;
endmodule
